// File: rtl/control_sequencer_if.sv
// ============================================================================
// Module      : control_sequencer_if
// Description : Decoder <-> sequencer control bundle (strobes in, state/PC out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface control_sequencer_if #(
    parameter int PC_WIDTH  = 16,
    parameter int CNT_WIDTH = 32
);
    logic                 sm_extra;
    logic                 stop;
    logic                 set_jump;
    logic                 pc_sload;
    logic                 pc_cnt_en;
    logic [PC_WIDTH-1:0]  pc_load_value;
    logic                 resume;
    logic [1:0]           state;
    logic [PC_WIDTH-1:0]  pc;
    logic                 jump;
    logic                 two_cycles_after_jump;
    logic                 halted;
    logic [CNT_WIDTH-1:0] retired_count;

    modport master (
        output sm_extra, stop, set_jump, pc_sload, pc_cnt_en, pc_load_value, resume,
        input  state, pc, jump, two_cycles_after_jump, halted, retired_count
    );

    modport slave (
        input  sm_extra, stop, set_jump, pc_sload, pc_cnt_en, pc_load_value, resume,
        output state, pc, jump, two_cycles_after_jump, halted, retired_count
    );
endinterface

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module      : control_sequencer
// Description : FETCH/EXEC1/EXEC2/HALT sequencer owning PC, jump timing and
//               retired-instruction count for the downstream decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
    parameter int PC_WIDTH  = 16,
    parameter int CNT_WIDTH = 32
) (
    input  wire logic           clk,
    input  wire logic           reset,
    control_sequencer_if.slave  bus
);
    localparam logic [1:0] c_FETCH = 2'b00;
    localparam logic [1:0] c_EXEC1 = 2'b01;
    localparam logic [1:0] c_EXEC2 = 2'b10;
    localparam logic [1:0] c_HALT  = 2'b11;

    localparam logic [PC_WIDTH-1:0]  c_PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [1:0]           r_jc;
    logic [CNT_WIDTH-1:0] r_retired;
    logic                 w_retire;

    // stop outranks sm_extra; HALT only leaves on resume
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_FETCH: w_state_nxt = bus.stop ? c_HALT : c_EXEC1;
            c_EXEC1: w_state_nxt = bus.stop ? c_HALT : (bus.sm_extra ? c_EXEC2 : c_FETCH);
            c_EXEC2: w_state_nxt = bus.stop ? c_HALT : c_FETCH;
            default: w_state_nxt = bus.resume ? c_FETCH : c_HALT;
        endcase
    end

    assign w_retire = ((r_state == c_EXEC1) || (r_state == c_EXEC2)) && (w_state_nxt == c_FETCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_FETCH;
            r_pc      <= '0;
            r_jc      <= 2'd0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state != c_HALT) begin
                if (bus.pc_sload) begin
                    r_pc <= bus.pc_load_value;
                end else if (bus.pc_cnt_en) begin
                    r_pc <= r_pc + c_PC_ONE;
                end
            end

            if (w_retire) begin
                r_retired <= r_retired + c_CNT_ONE;
            end

            // a fresh set_jump restarts the two-cycle window even mid-window
            if (w_state_nxt == c_HALT) begin
                r_jc <= 2'd0;
            end else if (bus.set_jump && (r_state != c_HALT)) begin
                r_jc <= 2'd2;
            end else if (r_jc != 2'd0) begin
                r_jc <= r_jc - 2'd1;
            end
        end
    end

    assign bus.state                 = r_state;
    assign bus.pc                    = r_pc;
    assign bus.jump                  = (r_jc != 2'd0);
    assign bus.two_cycles_after_jump = (r_jc == 2'd1);
    assign bus.halted                = (r_state == c_HALT);
    assign bus.retired_count         = r_retired;

endmodule

`default_nettype wire
